plru_set_assoc: RTL
===================

// Module: plru_set_assoc
// PURPOSE
//  Tree pseudo-LRU replacement controller for a SETS x WAYS set-associative cache.
//  Holds WAYS-1 tree bits and WAYS valid bits per set; promotes ways on hit and
//  returns a registered victim way on miss (invalid ways are filled first).
//  Multi-cycle flush sequencer; per-way invalidate.
//  Sits between the IFU cache controller tag-compare stage and the data/tag write.
// PARAMETERS
//  WAYS   16  ways per set; power of 2, >=2; WAY_W = $clog2(WAYS)
//  SETS    8  sets; power of 2, >=1; SET_W = max(1,$clog2(SETS))
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous reset, active-high
//  access_valid   in   1      lookup result presented; accepted when access_ready=1
//  access_ready   out  1      0 while flush is in progress
//  access_set     in   SET_W  set index of the access
//  access_hit     in   1      1=hit (promote access_way), 0=miss (allocate victim)
//  access_way     in   WAY_W  hit way; ignored on miss
//  inval_valid    in   1      invalidate one way (clear valid bit only)
//  inval_set      in   SET_W  set to invalidate
//  inval_way      in   WAY_W  way to invalidate
//  flush_req      in   1      pulse: clear valid bits and tree bits of all sets
//  victim_valid   out  1      1-cycle pulse, one cycle after an accepted miss
//  victim_way     out  WAY_W  way to fill; stable until next victim_valid
//  victim_was_inv out  1      1 = victim was an invalid way (no eviction needed)
//  lock_mask      in   WAYS   (PLRU_LOCK_EN only) 1 = way must not be victimised
//  lock_err       out  1      (PLRU_LOCK_EN only) all ways locked at miss time
// BEHAVIOUR
//  Reset: all tree bits 0, all valid bits 0, flush FSM IDLE, access_ready=1,
//   victim_valid=0, victim_way=0, victim_was_inv=0, lock_err=0.
//  Tree: heap order; node n has children 2n+1/2n+2; leaf node L = way L-(WAYS-1).
//   Bit 0 = next victim is on the left subtree, 1 = right.
//  Promote(w): every node on the root->w path points away from w; other bits hold.
//  Hit (access accepted, access_hit=1): promote(access_way); valid bits unchanged.
//  Miss: victim = lowest-index way with valid=0 if any (victim_was_inv=1), else the
//   tree walk from root following the bits (victim_was_inv=0). Then promote(victim),
//   set valid[victim]. Victim is computed from state at the accepting edge; result
//   registered -> victim_valid exactly 1 cycle later.
//  Back-to-back accesses to one set: the second sees the first's update.
//  inval_valid: clears valid[inval_set][inval_way] at the next edge; tree untouched.
//   Same cycle as a miss to the same set: victim uses pre-edge state; valid clear
//   wins if it targets the allocated way.
//  Flush FSM: IDLE -(flush_req)-> FLUSH; FLUSH clears set index cnt (0..SETS-1) one
//   set per cycle; after set SETS-1 -> IDLE. access_ready=0 in FLUSH; flush_req
//   asserted while in FLUSH is ignored. Access and flush_req in same IDLE cycle: the
//   access is accepted and its victim still pulses; flush starts next cycle.
//   inval_valid ignored in FLUSH.
//  Async reset mid-flush: immediate return to reset state, access_ready=1.
// CONFIGURATION
//  PLRU_LOCK_EN defined: invalid-first search skips locked ways; during the walk, if
//   the subtree a node points to is fully locked, take the other child. If all WAYS
//   are locked: victim = plain tree walk, lock_err=1 together with victim_valid.
//   Hits to locked ways still promote.
//  PLRU_LOCK_EN undefined: lock_mask/lock_err ports absent; behaviour as above.
// TESTING
//  (defaults WAYS=16, SETS=8)
//  Reset, 16 misses to set 0 -> victim_way 0..15 in order, victim_was_inv=1 each.
//  Then miss set 0 -> victim 0, was_inv=0; hit way 0, miss -> victim 8.
//  Invalidate set 0 way 5, miss set 0 -> victim 5, was_inv=1; set 1 state untouched.
//  flush_req -> access_ready low exactly 8 cycles; then miss set 3 -> victim 0, inv=1.
//  Miss + inval of that set/way same cycle -> victim pulses, next miss reuses that way.
//  PLRU_LOCK_EN: fill set 0, lock_mask=0x00FF, miss -> victim 8; lock 0xFFFF -> lock_err=1.

Source files
------------

// File: rtl/plru_set_assoc_if.sv
// Access / invalidate / victim bus of the tree-PLRU replacement controller.
// Lock ports exist only when PLRU_LOCK_EN is defined.
interface plru_set_assoc_if #(
  parameter int WAYS = 16,
  parameter int SETS = 8
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

  logic             access_valid;
  logic             access_ready;
  logic [SET_W-1:0] access_set;
  logic             access_hit;
  logic [WAY_W-1:0] access_way;
  logic             inval_valid;
  logic [SET_W-1:0] inval_set;
  logic [WAY_W-1:0] inval_way;
  logic             flush_req;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             victim_was_inv;
`ifdef PLRU_LOCK_EN
  logic [WAYS-1:0]  lock_mask;
  logic             lock_err;

  modport master (
    output access_valid, access_set, access_hit, access_way,
           inval_valid, inval_set, inval_way, flush_req, lock_mask,
    input  access_ready, victim_valid, victim_way, victim_was_inv, lock_err
  );
  modport slave (
    input  access_valid, access_set, access_hit, access_way,
           inval_valid, inval_set, inval_way, flush_req, lock_mask,
    output access_ready, victim_valid, victim_way, victim_was_inv, lock_err
  );
`else
  modport master (
    output access_valid, access_set, access_hit, access_way,
           inval_valid, inval_set, inval_way, flush_req,
    input  access_ready, victim_valid, victim_way, victim_was_inv
  );
  modport slave (
    input  access_valid, access_set, access_hit, access_way,
           inval_valid, inval_set, inval_way, flush_req,
    output access_ready, victim_valid, victim_way, victim_was_inv
  );
`endif
endinterface

// File: rtl/plru_set_assoc.sv
// Tree pseudo-LRU replacement controller: per-set tree + valid bits, invalid-first
// victim select, per-way invalidate, multi-cycle flush. Optional lock: PLRU_LOCK_EN.
module plru_set_assoc #(
  parameter int WAYS = 16,
  parameter int SETS = 8
) (
  input logic            clk,
  input logic            rst,
  plru_set_assoc_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic [SET_W-1:0]           cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-2:0]  tree_q;
  logic [SETS-1:0][WAYS-1:0]  valid_q;

  logic [WAYS-2:0]  cur_tree, new_tree;
  logic [WAYS-1:0]  cur_valid, lock;
  logic             acc_go, miss_go, inval_go, inv_found, all_locked;
  logic [WAY_W-1:0] inv_way, walk_way, vic_way, prom_way;

  logic             vv_q, vi_q, le_q;
  logic [WAY_W-1:0] vw_q;

`ifdef PLRU_LOCK_EN
  assign lock = bus.lock_mask;
`else
  assign lock = '0;
`endif
  assign all_locked = &lock;

  assign acc_go    = bus.access_valid && (state_q == IDLE);
  assign miss_go   = acc_go && !bus.access_hit;
  assign inval_go  = bus.inval_valid && (state_q == IDLE);
  assign cur_tree  = tree_q[bus.access_set];
  assign cur_valid = valid_q[bus.access_set];

  // Lowest-index invalid way wins: scan downward, last hit overrides.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!cur_valid[w] && !lock[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
  end

  // Walk root->leaf; pfx holds the way-index bits chosen so far.
  always_comb begin
    int   pfx;
    logic dir;
    logic sub_lk;
    pfx    = 0;
    dir    = 1'b0;
    sub_lk = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = cur_tree[(1 << l) - 1 + pfx];
      sub_lk = 1'b1;
      for (int w = 0; w < WAYS; w++)
        if ((w >> (WAY_W - l - 1)) == (pfx * 2 + int'(dir)))
          sub_lk = sub_lk & lock[w];
      if (sub_lk && !all_locked)
        dir = ~dir;
      pfx = pfx * 2 + int'(dir);
    end
    walk_way = WAY_W'(pfx);
  end

  assign vic_way  = inv_found ? inv_way : walk_way;
  assign prom_way = bus.access_hit ? bus.access_way : vic_way;

  // Every node on the path to prom_way points to the opposite child.
  always_comb begin
    new_tree = cur_tree;
    for (int l = 0; l < WAY_W; l++)
      new_tree[(1 << l) - 1 + int'(prom_way >> (WAY_W - l))] = ~prom_way[WAY_W - 1 - l];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_W'(SETS - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // Invalidate is written after the allocate so a clear of the same way wins.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tree_q  <= '0;
      valid_q <= '0;
    end else if (state_q == FLUSH) begin
      tree_q[cnt_q]  <= '0;
      valid_q[cnt_q] <= '0;
    end else begin
      if (acc_go) begin
        tree_q[bus.access_set] <= new_tree;
        if (!bus.access_hit)
          valid_q[bus.access_set][vic_way] <= 1'b1;
      end
      if (inval_go)
        valid_q[bus.inval_set][bus.inval_way] <= 1'b0;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vv_q <= 1'b0;
      vw_q <= '0;
      vi_q <= 1'b0;
      le_q <= 1'b0;
    end else begin
      vv_q <= miss_go;
      le_q <= miss_go && all_locked;
      if (miss_go) begin
        vw_q <= vic_way;
        vi_q <= inv_found;
      end
    end

  assign bus.access_ready   = (state_q == IDLE);
  assign bus.victim_valid   = vv_q;
  assign bus.victim_way     = vw_q;
  assign bus.victim_was_inv = vi_q;
`ifdef PLRU_LOCK_EN
  assign bus.lock_err       = le_q;
`endif
endmodule
